// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and validity helper
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - combinational single BCD digit cell; down path built with BCD_CNT_DOWN_EN
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       ci,
`ifdef BCD_CNT_DOWN_EN
    input  logic       bi,
    output logic       bo,
`endif
    output bcd_digit_t nd,
    output logic       co
);

    // ci and bi are never both high: the top only issues one direction per cycle.
    always_comb begin
        nd = d;
        co = 1'b0;
`ifdef BCD_CNT_DOWN_EN
        bo = 1'b0;
`endif
        if (ci) begin
            if (d == BCD_MAX) begin
                nd = BCD_MIN;
                co = 1'b1;
            end else begin
                nd = d + 4'd1;
            end
        end
`ifdef BCD_CNT_DOWN_EN
        else if (bi) begin
            if (d == BCD_MIN) begin
                nd = BCD_MAX;
                bo = 1'b1;
            end else begin
                nd = d - 4'd1;
            end
        end
`endif
    end

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - N-digit registered BCD counter; BCD_CNT_DOWN_EN adds dec/borrow
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                inc,
`ifdef BCD_CNT_DOWN_EN
    input  logic                dec,
`endif
    input  logic                sat,
    output logic [4*DIGITS-1:0] q,
    output logic                carry,
    output logic                borrow,
    output logic                load_err
);

    logic [4*DIGITS-1:0] q_next;
    logic [DIGITS:0]     c;
    logic                load_ok;

`ifdef BCD_CNT_DOWN_EN
    logic [DIGITS:0] b;
    logic            borrow_r;

    assign c[0]   = inc & ~dec;
    assign b[0]   = dec & ~inc;
    assign borrow = borrow_r;
`else
    assign c[0]   = inc;
    assign borrow = 1'b0;
`endif

    // Carry/borrow out of the top digit means q was all-9s / all-0s.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .d  (q[4*i +: 4]),
            .ci (c[i]),
`ifdef BCD_CNT_DOWN_EN
            .bi (b[i]),
            .bo (b[i+1]),
`endif
            .nd (q_next[4*i +: 4]),
            .co (c[i+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            carry    <= 1'b0;
            load_err <= 1'b0;
`ifdef BCD_CNT_DOWN_EN
            borrow_r <= 1'b0;
`endif
        end else begin
            carry    <= 1'b0;
            load_err <= 1'b0;
`ifdef BCD_CNT_DOWN_EN
            borrow_r <= 1'b0;
`endif
            if (clr) begin
                q <= '0;
            end else if (load) begin
                if (load_ok) q <= load_val;
                else         load_err <= 1'b1;
            end else if (c[DIGITS]) begin
                carry <= 1'b1;
                if (!sat) q <= q_next;
            end
`ifdef BCD_CNT_DOWN_EN
            else if (b[DIGITS]) begin
                borrow_r <= 1'b1;
                if (!sat) q <= q_next;
            end
`endif
            else begin
                q <= q_next;
            end
        end
    end

endmodule
